// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline stage: control/data bundles under valid/ready, flush, bubble counter.
// Define PIPE_SKID_EN for the 2-entry version with a skid register and a fully registered in_ready.
module pipe_stage_elastic #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // A transfer happens on an edge where valid and ready are both high; once valid is
  // raised with an entry, that entry and its bundles stay stable until taken or flushed.
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_main;

  assign out_valid  = valid_q;
  assign out_ctrl   = ctrl_q;
  assign out_data   = data_q;
  assign bubble_cnt = cnt_q;
  assign load_main  = ~valid_q | out_ready;

`ifdef PIPE_SKID_EN
  logic              sk_valid;
  logic [CTRL_W-1:0] sk_ctrl;
  logic [DATA_W-1:0] sk_data;
  logic              acc;

  assign in_ready = ~sk_valid;
  assign acc      = in_valid & ~sk_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      data_q   <= '0;
      sk_valid <= 1'b0;
      sk_ctrl  <= '0;
      sk_data  <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      sk_valid <= 1'b0;
      sk_ctrl  <= '0;
    end else if (load_main) begin
      // Skid is older than anything at the input, so it refills main first.
      if (sk_valid) begin
        valid_q  <= 1'b1;
        ctrl_q   <= sk_ctrl;
        data_q   <= sk_data;
        sk_valid <= 1'b0;
        sk_ctrl  <= '0;
      end else if (acc) begin
        valid_q <= 1'b1;
        ctrl_q  <= in_ctrl;
        data_q  <= in_data;
      end else begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end
    end else if (acc) begin
      sk_valid <= 1'b1;
      sk_ctrl  <= in_ctrl;
      sk_data  <= in_data;
    end
  end
`else
  assign in_ready = load_main;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_main) begin
      // A bubble zeroes control but leaves the old data bundle in place.
      valid_q <= in_valid;
      ctrl_q  <= in_valid ? in_ctrl : '0;
      if (in_valid) data_q <= in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (clr_cnt)
      cnt_q <= '0;
    else if (!valid_q && cnt_q != {CNT_W{1'b1}})
      cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios then random traffic against a queue model.
// Follows PIPE_SKID_EN to pick the stage capacity (1 or 2 entries).
module tb_pipe_stage_elastic;
  localparam int CTRL_W = 5;
  localparam int DATA_W = 101;
  localparam int CNT_W  = 4;
  localparam int W      = CTRL_W + DATA_W;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              clr_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .clr_cnt(clr_cnt), .bubble_cnt(bubble_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard: entries held by the stage, oldest first, as {ctrl, data}
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] last_data;
  int                cnt_m;
  int                checks;
  int                failures;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_data = '0;
    cnt_m = 0;
  endtask

  function automatic bit model_ready();
    if (CAP == 2) return exp_q.size() < 2;
    return exp_q.size() == 0 || out_ready;
  endfunction

  task automatic check_outputs(input string tag);
    logic [W-1:0] head;
    bit has;
    has  = exp_q.size() > 0;
    head = has ? exp_q[0] : '0;
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(has));
    chk({tag, ".out_ctrl"}, 128'(out_ctrl), has ? 128'(head[W-1:DATA_W]) : 128'(0));
    chk({tag, ".out_data"}, 128'(out_data), has ? 128'(head[DATA_W-1:0]) : 128'(last_data));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(model_ready()));
    chk({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(cnt_m));
  endtask

  // one clock: check before the edge, advance the model across it
  task automatic cycle(input string tag);
    bit rdy, drain, acc, empty;
    logic [W-1:0] head;
    @(negedge clk);
    check_outputs(tag);
    rdy   = model_ready();
    empty = exp_q.size() == 0;
    drain = !empty && out_ready;
    acc   = in_valid && rdy;
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      if (clr_cnt) cnt_m = 0;
      else if (empty && cnt_m < CNT_MAX) cnt_m++;
      if (flush) exp_q.delete();
      else begin
        if (drain) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({in_ctrl, in_data});
      end
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        last_data = head[DATA_W-1:0];
      end
    end
  endtask

  // driver tasks
  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ordy, input bit fl, input bit clr);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    rst = 1'b0;
    drive(0, '0, '0, 1, 0, 0);
    @(posedge clk);
    #1;
    cycle("reset0");
    cycle("reset1");
    rst = 1'b1;

    // reset then stream data 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'h1F, DATA_W'(i), 1, 0, 0);
      cycle("stream");
    end
    drive(0, 5'h00, '0, 1, 0, 0);
    cycle("stream_tail");
    cycle("stream_idle");

    // stall with 0xAA held, 0xBB offered
    drive(1, 5'h0A, DATA_W'('hAA), 0, 0, 0);
    cycle("stall_load");
    drive(1, 5'h0B, DATA_W'('hBB), 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("stall");
    drive(0, 5'h1F, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("stall_release");

    // flush with a simultaneous accept
    drive(1, 5'h05, DATA_W'('h55), 1, 0, 0);
    cycle("flush_load");
    drive(1, 5'h0C, DATA_W'('hCC), 1, 1, 0);
    cycle("flush");
    drive(0, 5'h1F, DATA_W'('hDD), 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle("flush_after");

    // bubble ctrl zeroing and counter saturation
    for (int i = 0; i < 20; i++) cycle("idle_sat");
    drive(0, 5'h1F, '0, 1, 0, 1);
    cycle("clr");
    drive(0, 5'h1F, '0, 1, 0, 0);
    cycle("clr_after");
    cycle("clr_after2");

    // async reset mid-stall, skid filled when present
    drive(1, 5'h0A, DATA_W'('hAA), 0, 0, 0);
    cycle("ar_load");
    drive(1, 5'h0B, DATA_W'('hBB), 0, 0, 0);
    cycle("ar_fill");
    cycle("ar_hold");
    rst = 1'b0;
    #2;
    model_reset();
    chk("async_rst.out_valid", 128'(out_valid), 128'(0));
    chk("async_rst.out_ctrl", 128'(out_ctrl), 128'(0));
    chk("async_rst.in_ready", 128'(in_ready), 128'(1));
    chk("async_rst.bubble_cnt", 128'(bubble_cnt), 128'(0));
    cycle("ar_low");
    rst = 1'b1;
    drive(0, '0, '0, 1, 0, 0);
    cycle("ar_release");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, CTRL_W'($urandom), rand_data(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 15) == 0);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed EX/MEM-style pipeline registers.
- One generic pipeline stage carrying a control bundle and a data bundle under a valid/ready handshake.
- Supports stall (backpressure), flush (bubble insertion), control zeroing on bubbles, and a saturating bubble counter for performance debug.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with per-stage widths.

Parameters:
- CTRL_W, 5: width of the control bundle (regWrite, memtoReg, memRead, memWrite, ...). Forced to 0 whenever the stage holds a bubble.
- DATA_W, 101: width of the data bundle (PC, ALU result, rs2 data, rd, ...). Not cleared on bubble.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- flush, input, 1: kill all held entries this cycle.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept an entry.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: stage holds a valid entry.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: held control; 0 when out_valid=0.
- out_data, output, DATA_W: held data.
- clr_cnt, input, 1: synchronous clear of bubble_cnt.
- bubble_cnt, output, CNT_W: count of cycles with out_valid=0, saturating.

Behaviour:
- Handshakes:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (drain) = out_valid & out_ready.
- Main register: valid_q, ctrl_q, data_q.
  - out_valid = valid_q; out_ctrl = ctrl_q; out_data = data_q.
  - Invariant: ctrl_q = 0 whenever valid_q = 0.
- Reset (rst=0, async):
  - valid_q=0, ctrl_q=0, data_q=0, bubble_cnt=0, skid entry empty.
  - in_ready reads 1 immediately after reset release.
- Latency: 1 cycle in -> out. Throughput: 1 entry per cycle when out_ready=1.
- Priority per rising edge: flush > drain/acc updates.
- Flush:
  - valid_q<=0, ctrl_q<=0, skid cleared; data_q holds.
  - An acc in the same cycle completes the handshake but the entry is discarded.
  - out_valid=0 on the next cycle.
- Stall: out_valid=1, out_ready=0, flush=0 -> main register holds all bits unchanged.
- Data loading:
  - When the main register loads with in_valid=0 (bubble), ctrl_q<=0 and data_q holds its old value.
  - Once presented with out_valid=1, out_ctrl/out_data must stay stable until drain or flush.
- Bubble counter:
  - Increments by 1 each cycle out_valid=0 (sampled at the edge).
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt=1 -> 0 on that edge; clr_cnt has priority over increment.
  - Flush does not clear the counter.
- Reset mid-operation: all in-flight entries are lost; no partial handshake survives.

Optional Feature:
- Macro PIPE_SKID_EN.
- Defined: a 2-entry elastic stage.
  - Adds skid register sk_valid/sk_ctrl/sk_data.
  - in_ready = ~sk_valid, purely registered with no combinational path from out_ready.
  - acc while valid_q=1 and no drain -> entry goes to skid.
  - On drain: skid (if valid) moves to main, else acc loads main, else main becomes a bubble.
  - Order is preserved (FIFO). Skid ctrl obeys the same zero-on-empty rule.
- Undefined: single-entry stage.
  - in_ready = ~valid_q | out_ready (combinational).
  - On each edge where in_ready=1: main <= input (bubble if in_valid=0).

Test Plan:
- Reset then stream: rst low 2 cycles, in_valid=1, ctrl 5'h1F, data 1..4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each; bubble_cnt=1 after the first cycle.
- Stall: hold entry data=0xAA, ctrl=5'h0A, out_ready=0 for 3 cycles -> out_valid=1, outputs unchanged. Without skid in_ready=0 throughout. With skid, one more entry (0xBB) accepted, then in_ready=0; on release, 0xAA then 0xBB out.
- Flush with simultaneous acc: valid_q=1, flush=1, in_valid=1 data 0xCC -> next cycle out_valid=0, out_ctrl=0; 0xCC never appears; data_q keeps its old value.
- Bubble ctrl zeroing: in_valid=0 with in_ctrl=5'h1F, out_ready=1 -> out_valid=0, out_ctrl=0.
- Counter saturation: CNT_W=4, idle 20 cycles -> bubble_cnt=15 and holds; clr_cnt=1 -> 0, then 1 on the next idle cycle.
- Async reset mid-stall: rst low between edges while holding 0xAA (skid full) -> out_valid=0, out_ctrl=0, in_ready=1 without a clock edge.
